// File: rtl/rf_pkg.sv
// Shared types and defaults for the integer register file.
// Address width is derived from the register count.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Width of a register index; a single register still needs one bit
    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int AW_DEF = addr_width(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for in-flight producers.
// Issue beats flush, flush beats writeback; register 0 is never busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             flush,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    output logic [NREGS-1:0] busy,
    output logic             busy_any
);

    logic [NREGS-1:0] busy_next;

    // Next busy state per register, highest-priority event first
    always_comb begin
        busy_next = busy;
        for (int r = 1; r < NREGS; r++) begin
            if (issue_valid && issue_rd == AW'(r)) begin
                busy_next[r] = 1'b1;
            end else if (flush) begin
                busy_next[r] = 1'b0;
            end else if (wen && waddr == AW'(r)) begin
                busy_next[r] = 1'b0;
            end
        end
        busy_next[0] = 1'b0;
    end

    // Busy state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_any = |busy[NREGS-1:1];

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with write-to-read bypass and busy scoreboard.
// Outputs are forced to zero while reset is asserted.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic                flush,
    output logic                busy_any,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    localparam bit BYP = (BYPASS != 0);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_vec;
    logic             busy_any_raw;

    // Register storage; entry 0 is reset to zero and never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wen && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .wen         (wen),
        .waddr       (waddr),
        .busy        (busy_vec),
        .busy_any    (busy_any_raw)
    );

    // Read ports: array lookup with optional same-cycle writeback forwarding
    always_comb begin
        rdata = '0;
        rbusy = '0;
        if (!rst) begin
            for (int i = 0; i < NRD; i++) begin
                if (BYP && wen && waddr != '0
                    && waddr == raddr[i*AW +: AW]) begin
                    rdata[i*XLEN +: XLEN] = wdata;
                    rbusy[i]              = 1'b0;
                end else begin
                    rdata[i*XLEN +: XLEN] = regs[raddr[i*AW +: AW]];
                    rbusy[i]              = busy_vec[raddr[i*AW +: AW]];
                end
            end
        end
    end

    assign busy_any = !rst && busy_any_raw;
    assign dbg_data = rst ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed bench for reg_file_sb.
// Runs a bypassing and a non-bypassing instance against one reference model.
module tb_reg_file_sb;
    import rf_pkg::*;

    localparam int AW   = AW_DEF;
    localparam int NRD  = 2;
    localparam int XL   = XLEN_DEF;
    localparam int NR   = NREGS_DEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NRD*AW-1:0] raddr;
    logic              wen;
    reg_idx_t          waddr;
    xword_t            wdata;
    logic              issue_valid;
    reg_idx_t          issue_rd;
    logic              flush;
    reg_idx_t          dbg_addr;

    logic [NRD*XL-1:0] rdata_b, rdata_n;
    logic [NRD-1:0]    rbusy_b, rbusy_n;
    logic              busy_any_b, busy_any_n;
    xword_t            dbg_data_b, dbg_data_n;

    int n_tests = 0;
    int n_fail  = 0;

    xword_t m_regs [NR];
    bit     m_busy [NR];

    reg_file_sb #(.BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b),
        .rbusy(rbusy_b), .wen(wen), .waddr(waddr), .wdata(wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .busy_any(busy_any_b), .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
    );

    reg_file_sb #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n),
        .rbusy(rbusy_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .busy_any(busy_any_n), .dbg_addr(dbg_addr), .dbg_data(dbg_data_n)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic xword_t exp_rd(input int a, input bit byp);
        if (rst) return '0;
        if (byp && wen && a != 0 && int'(waddr) == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input int a, input bit byp);
        if (rst) return 1'b0;
        if (byp && wen && a != 0 && int'(waddr) == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit exp_any();
        bit any = 1'b0;
        if (rst) return 1'b0;
        for (int r = 1; r < NR; r++) any |= m_busy[r];
        return any;
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < NRD; i++) begin
            int a = int'(raddr[i*AW +: AW]);
            check($sformatf("rdata%0d_byp x%0d", i, a),
                  rdata_b[i*XL +: XL], exp_rd(a, 1'b1));
            check($sformatf("rdata%0d_nobyp x%0d", i, a),
                  rdata_n[i*XL +: XL], exp_rd(a, 1'b0));
            check($sformatf("rbusy%0d_byp x%0d", i, a),
                  rbusy_b[i], exp_busy(a, 1'b1));
            check($sformatf("rbusy%0d_nobyp x%0d", i, a),
                  rbusy_n[i], exp_busy(a, 1'b0));
        end
        check("busy_any_byp", busy_any_b, exp_any());
        check("busy_any_nobyp", busy_any_n, exp_any());
        check("dbg_byp", dbg_data_b, rst ? '0 : m_regs[dbg_addr]);
        check("dbg_nobyp", dbg_data_n, rst ? '0 : m_regs[dbg_addr]);
    endtask

    task automatic model_update();
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (wen && waddr != 0) begin
                m_regs[waddr] = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (flush) begin
                for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    endtask

    // check current outputs, advance one edge, then update the model
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    task automatic set_raddr(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        idle();
        set_raddr(0, 0);
        dbg_addr = '0;
        rst = 1'b1;
        #1;
        step();
        step();
        rst = 1'b0;

        // reset state on every register, both ports
        for (int i = 0; i < NR; i++) begin
            set_raddr(i, NR - 1 - i);
            dbg_addr = reg_idx_t'(i);
            step();
        end

        // first write becomes readable next cycle
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        set_raddr(1, 2);
        step();
        idle();
        set_raddr(5, 5);
        #1;
        check("x5_after_write", rdata_n[XL-1:0], 32'hDEADBEEF);
        step();

        // register 0 ignores writes and issues
        wen = 1'b1; waddr = '0; wdata = 32'h1234;
        issue_valid = 1'b1; issue_rd = '0;
        step();
        idle();
        set_raddr(0, 0);
        #1;
        check("x0_data", rdata_b[XL-1:0], 32'h0);
        check("x0_busy", rbusy_b, 2'b00);
        check("x0_busy_any", busy_any_b, 1'b0);
        step();

        // bypass vs no bypass, with x7 busy beforehand
        wen = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        set_raddr(7, 1);
        dbg_addr = 5'd7;
        #1;
        check("bypass_data", rdata_b[XL-1:0], 32'hA5A5A5A5);
        check("bypass_busy", rbusy_b[0], 1'b0);
        check("nobypass_data", rdata_n[XL-1:0], 32'h11111111);
        check("nobypass_busy", rbusy_n[0], 1'b1);
        check("dbg_old_value", dbg_data_b, 32'h11111111);
        step();
        idle();

        // issue, writeback, then both in one cycle
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        idle();
        set_raddr(3, 3);
        #1;
        check("x3_busy", rbusy_n, 2'b11);
        check("x3_busy_any", busy_any_n, 1'b1);
        wen = 1'b1; waddr = 5'd3; wdata = 32'h33;
        step();
        idle();
        #1;
        check("x3_cleared", rbusy_n, 2'b00);
        wen = 1'b1; waddr = 5'd3; wdata = 32'h44;
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        idle();
        #1;
        check("x3_reissued_busy", rbusy_b[0], 1'b1);
        check("x3_new_data", rdata_b[XL-1:0], 32'h44);
        step();

        // flush clears everything; issue beats same-cycle flush
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_rd = 5'd10;
        step();
        idle();
        flush = 1'b1;
        step();
        idle();
        #1;
        check("flush_busy_any", busy_any_b, 1'b0);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd11;
        step();
        idle();
        set_raddr(11, 9);
        #1;
        check("flush_issue_busy", rbusy_b, 2'b01);
        check("flush_issue_any", busy_any_b, 1'b1);
        step();

        // reset overrides a same-cycle write and issue
        wen = 1'b1; waddr = 5'd4; wdata = 32'h55;
        step();
        rst = 1'b1; wen = 1'b1; waddr = 5'd4; wdata = 32'h66;
        issue_valid = 1'b1; issue_rd = 5'd4;
        set_raddr(4, 4);
        step();
        idle();
        #1;
        check("rst_x4_data", rdata_b[XL-1:0], 32'h0);
        check("rst_x4_busy", rbusy_b, 2'b00);
        check("rst_busy_any", busy_any_b, 1'b0);
        step();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst         = ($urandom_range(63) == 0);
            wen         = $urandom_range(1);
            waddr       = reg_idx_t'($urandom_range(NR - 1));
            wdata       = $urandom;
            issue_valid = ($urandom_range(4) < 2);
            issue_rd    = reg_idx_t'($urandom_range(NR - 1));
            flush       = ($urandom_range(15) == 0);
            dbg_addr    = reg_idx_t'($urandom_range(NR - 1));
            set_raddr($urandom_range(NR - 1), $urandom_range(NR - 1));
            if ($urandom_range(2) == 0) raddr[AW-1:0] = waddr;
            if ($urandom_range(3) == 0) raddr[2*AW-1:AW] = raddr[AW-1:0];
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised integer register file for the next npc core generation. Configurable width, depth and read-port count.
- Adds write-to-read bypass and a per-register busy scoreboard for the pipelined core.
- Includes a flush input and a side-effect-free debug read port for difftest register comparison.
- Sits between decode (read and issue) and writeback (write and retire).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of combinational read ports.
- BYPASS, 1, 1 = forward same-cycle write data to read ports; 0 = no forwarding.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- raddr  in  NRD*AW  read addresses, port i at [i*AW +: AW]; AW = $clog2(NREGS).
- rdata  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rbusy  out  NRD  1 = register on port i has an outstanding producer.
- wen  in  1  writeback write enable.
- waddr  in  AW  writeback destination.
- wdata  in  XLEN  writeback data.
- issue_valid  in  1  an instruction writing issue_rd is issued this cycle.
- issue_rd  in  AW  destination of the issued instruction.
- flush  in  1  pipeline squash; clears all busy bits.
- busy_any  out  1  OR of all busy bits (drain detection).
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data; never bypassed.

Behaviour:
- Register 0 reads 0 and is never busy. Writes, issues and clears to address 0 are ignored.
- Reset (rst=1 at an edge): all registers become 0 and all busy bits become 0. wen, issue_valid and flush are ignored that cycle.
- Outputs during and after reset: rdata=0, dbg_data=0, rbusy=0, busy_any=0 until the first write or issue.
- Write: wen=1 and waddr!=0 updates regs[waddr]=wdata at the edge; visible on a non-bypassed read the next cycle.
- Read: rdata[i] is combinational from regs[raddr[i]].
- Bypass (BYPASS=1): if wen && waddr==raddr[i] && waddr!=0, then rdata[i]=wdata and rbusy[i]=0 in the same cycle.
- BYPASS=0: the old value and the current busy bit are shown until the edge.
- Scoreboard next-state per register r!=0, priority high to low:
  1. rst → 0.
  2. issue_valid && issue_rd==r → 1. A new producer wins over a same-cycle flush or writeback.
  3. flush → 0.
  4. wen && waddr==r → 0.
  5. Otherwise hold.
- A writeback to a non-busy register is legal: the data is written and the busy bit is unaffected.
- Flush does not alter register contents; a same-cycle wen still writes.
- Issue takes effect at the next edge. rbusy never reflects a same-cycle issue.
- Multiple read ports with the same address return identical data and busy values.
- busy_any is combinational from the busy vector and excludes register 0.
- Debug port: dbg_data=regs[dbg_addr], combinational, no bypass, no effect on state.
- No X may propagate from unused ports: an address out of range is impossible given a power-of-two NREGS.

Decomposition:
- Package rf_pkg:
  - XLEN and NREGS defaults.
  - function clog2-based AW.
  - typedef reg_idx_t (logic [AW-1:0]) and typedef xword_t (logic [XLEN-1:0]).
- Sub-module rf_scoreboard:
  - Holds the NREGS busy bits and the priority logic.
  - Outputs the busy vector and busy_any.
  - reg_file_sb instantiates it and applies the bypass masking to rbusy.

Test Plan:
- Reset then read all 32 registers on both ports → all rdata=0, rbusy=0, busy_any=0. Then write x5=0xDEADBEEF → the read next cycle gives 0xDEADBEEF.
- Write x0=0x1234 and issue rd=0 → x0 reads 0, rbusy=0, busy_any stays 0.
- BYPASS=1: read raddr0=7 while wen, waddr=7, wdata=0xA5A5A5A5 in the same cycle → rdata0=0xA5A5A5A5 and rbusy0=0 that cycle; dbg_data(7) shows the old value until the edge. With BYPASS=0 → rdata0 shows the old value.
- Issue rd=3 → the next cycle rbusy=1 for x3, busy_any=1. Writeback x3 → busy clears at the edge. Then issue rd=3 and writeback x3 in the same cycle → x3 stays busy and holds the new data.
- Issue rd=9 and rd=10 on consecutive cycles, then flush → both busy bits clear, busy_any=0, values unchanged. Flush with a same-cycle issue rd=11 → only x11 is busy.
- Write x4=0x55, then assert rst mid-stream alongside wen to x4=0x66 and issue rd=4 → after the edge x4=0, not busy, busy_any=0.
